// File: rtl/uart_bram_seq_ctrl_pkg.sv
// Shared definitions for the UART <-> BRAM loopback sequencer.
//   - default buffer geometry (DEPTH / ADDR_W) and idle timeout
//   - FSM state encoding (FILL, RD_REQ, RD_WAIT, TX_LOAD, TX_WAIT)
//   - is_drain(): true for every state that belongs to the drain phase
// Imported by the sequencer top and by its bench.
package uart_bram_seq_ctrl_pkg;

  localparam int DEPTH_DEF        = 8;
  localparam int ADDR_W_DEF       = 3;
  localparam int TIMEOUT_CLKS_DEF = 104170;

  localparam logic [2:0] FILL    = 3'd0;
  localparam logic [2:0] RD_REQ  = 3'd1;
  localparam logic [2:0] RD_WAIT = 3'd2;
  localparam logic [2:0] TX_LOAD = 3'd3;
  localparam logic [2:0] TX_WAIT = 3'd4;

  function automatic logic is_drain(input logic [2:0] s);
    return (s != FILL);
  endfunction

endpackage

// File: rtl/uart_bram_seq_ctrl_idle_timer.sv
// Saturating idle counter used for the early-flush option of the sequencer
// (only instantiated when UART_BRAM_TIMEOUT_FLUSH_EN is defined).
// Ports:
//   clk     in  system clock
//   rst     in  synchronous reset, active-high
//   clr     in  restart the count from zero
//   run     in  count while high; counter held at zero while low
//   expired out high once the count has reached LIMIT (stays there)
module uart_bram_seq_ctrl_idle_timer #(
  parameter int LIMIT = 104170
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic expired
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr || !run) begin
      cnt <= '0;
    end else if (cnt != W'(LIMIT)) begin
      cnt <= cnt + W'(1);
    end
  end

  assign expired = (cnt == W'(LIMIT));

endmodule

// File: rtl/uart_bram_seq_ctrl.sv
// Sequencer between UART RX, a byte-wide single-port BRAM and UART TX.
// Received bytes are written to BRAM at consecutive addresses until the
// buffer holds DEPTH bytes; the buffer is then read back in address order and
// each byte is handed to the transmitter, waiting for TxDone between bytes.
// This block is the only master of the BRAM port.
//
// Optional feature (macro UART_BRAM_TIMEOUT_FLUSH_EN): an idle timer in FILL
// forces an early drain of a partially filled buffer after TIMEOUT_CLKS quiet
// clocks. Without the macro, draining starts only when the buffer is full.
//
// Handshakes: RxValid, TxStart, TxDone and Overrun are single-clock pulses;
// there is no back-pressure. TxData is held from the TxStart pulse until the
// matching TxDone. BramDout is valid one clock after BramAddr is presented.
//
// Ports:
//   Clk, Rst          clock, synchronous active-high reset
//   En                global enable (gates new RX writes and new reads)
//   RxValid, RxData   received byte strobe and data
//   BramWe/Addr/Din   BRAM write enable, address, write data
//   BramDout          BRAM read data
//   TxStart, TxData   transmit request pulse and byte
//   TxDone            transmitter finished pulse
//   ByteCount         bytes currently buffered (0..DEPTH)
//   Draining          high in any drain state
//   Overrun           pulse: an RX byte was dropped during a drain
// All outputs are registered.
module uart_bram_seq_ctrl
  import uart_bram_seq_ctrl_pkg::*;
#(
  parameter int DEPTH        = DEPTH_DEF,
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int TIMEOUT_CLKS = TIMEOUT_CLKS_DEF
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              En,
  input  logic              RxValid,
  input  logic [7:0]        RxData,
  output logic              BramWe,
  output logic [ADDR_W-1:0] BramAddr,
  output logic [7:0]        BramDin,
  input  logic [7:0]        BramDout,
  output logic              TxStart,
  output logic [7:0]        TxData,
  input  logic              TxDone,
  output logic [ADDR_W:0]   ByteCount,
  output logic              Draining,
  output logic              Overrun
);

  localparam logic [ADDR_W:0] LAST_SLOT = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] ONE_LEFT  = (ADDR_W+1)'(1);

  logic [2:0]        state;
  logic [ADDR_W-1:0] rd_ptr;
  logic              flush;

`ifdef UART_BRAM_TIMEOUT_FLUSH_EN
  logic timer_clr;
  logic timer_run;
  logic timer_expired;

  // The timer only ticks while there is something to flush; any received
  // byte or leaving FILL restarts it.
  assign timer_run = (state == FILL) && (ByteCount != '0);
  assign timer_clr = RxValid || (state != FILL);

  uart_bram_seq_ctrl_idle_timer #(
    .LIMIT(TIMEOUT_CLKS)
  ) u_idle_timer (
    .clk    (Clk),
    .rst    (Rst),
    .clr    (timer_clr),
    .run    (timer_run),
    .expired(timer_expired)
  );

  assign flush = timer_expired && (ByteCount != '0);
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CLKS == 0);
  assign flush          = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= FILL;
      rd_ptr    <= '0;
      BramWe    <= 1'b0;
      BramAddr  <= '0;
      BramDin   <= '0;
      TxStart   <= 1'b0;
      TxData    <= '0;
      ByteCount <= '0;
      Draining  <= 1'b0;
      Overrun   <= 1'b0;
    end else begin
      BramWe  <= 1'b0;
      TxStart <= 1'b0;
      Overrun <= 1'b0;

      case (state)
        FILL: begin
          if (flush) begin
            // Early drain of a partial buffer; a byte arriving on this very
            // clock cannot be stored any more.
            state    <= RD_REQ;
            rd_ptr   <= '0;
            Draining <= 1'b1;
            if (RxValid) Overrun <= 1'b1;
          end else if (RxValid && En) begin
            BramWe    <= 1'b1;
            BramAddr  <= ByteCount[ADDR_W-1:0];
            BramDin   <= RxData;
            ByteCount <= ByteCount + (ADDR_W+1)'(1);
            if (ByteCount == LAST_SLOT) begin
              state    <= RD_REQ;
              rd_ptr   <= '0;
              Draining <= 1'b1;
            end
          end
        end

        RD_REQ: begin
          BramAddr <= rd_ptr;
          if (En) state <= RD_WAIT;
        end

        // BramAddr registered at the end of RD_REQ is sampled by the BRAM
        // here; its data is on BramDout during TX_LOAD.
        RD_WAIT: state <= TX_LOAD;

        TX_LOAD: begin
          TxData  <= BramDout;
          TxStart <= 1'b1;
          state   <= TX_WAIT;
        end

        TX_WAIT: begin
          if (TxDone) begin
            rd_ptr    <= rd_ptr + ADDR_W'(1);
            ByteCount <= ByteCount - (ADDR_W+1)'(1);
            if (ByteCount == ONE_LEFT) begin
              state    <= FILL;
              Draining <= 1'b0;
            end else begin
              state <= RD_REQ;
            end
          end
        end

        default: begin
          state    <= FILL;
          Draining <= 1'b0;
        end
      endcase

      // The buffer is busy while draining: incoming bytes are lost.
      if (RxValid && is_drain(state)) Overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_bram_seq_ctrl.sv
// Directed bench for uart_bram_seq_ctrl: BRAM model, auto-responding TX
// model (TxDone 20 clocks after each TxStart), expected-byte queue for the
// transmitted stream, and directed fill/drain/overrun/enable/reset cases.
// Honours UART_BRAM_TIMEOUT_FLUSH_EN for the early-flush case.
module tb_uart_bram_seq_ctrl;
  import uart_bram_seq_ctrl_pkg::*;

  localparam int DEPTH      = DEPTH_DEF;
  localparam int ADDR_W     = ADDR_W_DEF;
  localparam int TB_TIMEOUT = 100;

  // clock / reset
  logic Clk = 1'b0;
  logic Rst;
  always #5 Clk = ~Clk;

  logic              En;
  logic              RxValid;
  logic [7:0]        RxData;
  logic              BramWe;
  logic [ADDR_W-1:0] BramAddr;
  logic [7:0]        BramDin;
  logic [7:0]        BramDout;
  logic              TxStart;
  logic [7:0]        TxData;
  logic              TxDone;
  logic [ADDR_W:0]   ByteCount;
  logic              Draining;
  logic              Overrun;

  uart_bram_seq_ctrl #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .TIMEOUT_CLKS(TB_TIMEOUT)
  ) dut (
    .Clk(Clk), .Rst(Rst), .En(En), .RxValid(RxValid), .RxData(RxData),
    .BramWe(BramWe), .BramAddr(BramAddr), .BramDin(BramDin),
    .BramDout(BramDout), .TxStart(TxStart), .TxData(TxData),
    .TxDone(TxDone), .ByteCount(ByteCount), .Draining(Draining),
    .Overrun(Overrun)
  );

  // BRAM model: synchronous read-first single port
  logic [7:0] mem [DEPTH];
  logic       bad_write = 1'b0;
  always @(posedge Clk) begin
    if (BramWe) begin
      mem[BramAddr] <= BramDin;
      if (BramDin == 8'h7A) bad_write <= 1'b1;
    end
    BramDout <= mem[BramAddr];
  end

  // scoreboard
  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // TX model and pulse monitors (sampled on the falling edge)
  int tx_cnt   = 0;
  int done_cnt = 0;
  int ovr_cnt  = 0;
  int done_cd  = 0;
  initial begin
    TxDone = 1'b0;
    forever begin
      @(negedge Clk);
      TxDone = 1'b0;
      if (Overrun) ovr_cnt++;
      if (TxStart) begin
        tx_cnt++;
        if (exp_q.size() == 0) check("tx_unexpected", 32'(TxData), 32'hFFFF_FFFF);
        else check("tx_data", 32'(TxData), 32'(exp_q.pop_front()));
        done_cd = 20;
      end else if (done_cd > 0) begin
        done_cd--;
        if (done_cd == 0) begin
          TxDone = 1'b1;
          done_cnt++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    RxData  = b;
    RxValid = 1'b1;
    @(negedge Clk);
    RxValid = 1'b0;
  endtask

  // Sends n consecutive bytes and checks each resulting BRAM write.
  task automatic fill(input logic [7:0] base, input int n, input bit push);
    for (int i = 0; i < n; i++) begin
      if (i > 0) tick(1);
      send_byte(base + 8'(i));
      check("fill_we", 32'(BramWe), 32'd1);
      check("fill_addr", 32'(BramAddr), 32'(i));
      check("fill_din", 32'(BramDin), 32'(base + 8'(i)));
      check("fill_count", 32'(ByteCount), 32'(i + 1));
      if (push) exp_q.push_back(base + 8'(i));
    end
  endtask

  task automatic wait_idle(input int bound);
    int k = 0;
    while (!(Draining == 1'b0 && ByteCount == '0) && k < bound) begin
      tick(1);
      k++;
    end
    check("drain_end_in_time", 32'(k < bound), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_we"},    32'(BramWe),    32'd0);
    check({tag, "_addr"},  32'(BramAddr),  32'd0);
    check({tag, "_start"}, 32'(TxStart),   32'd0);
    check({tag, "_txd"},   32'(TxData),    32'd0);
    check({tag, "_count"}, 32'(ByteCount), 32'd0);
    check({tag, "_drain"}, 32'(Draining),  32'd0);
    check({tag, "_ovr"},   32'(Overrun),   32'd0);
  endtask

  int lat;
  int tx_base;
  int done_base;
  int k;

  initial begin
    Rst = 1'b1; En = 1'b1; RxValid = 1'b0; RxData = 8'h00;
    tick(3);
    check_all_zero("reset");
    Rst = 1'b0;
    tick(1);
    check("post_reset_count", 32'(ByteCount), 32'd0);

    // fill 0x61..0x68, drain starts when full
    fill(8'h61, DEPTH, 1'b1);
    check("full_draining", 32'(Draining), 32'd1);
    check("full_count", 32'(ByteCount), 32'(DEPTH));

    lat = 0;
    while (!TxStart && lat < 10) begin
      tick(1);
      lat++;
    end
    check("rd_req_to_txstart_latency", 32'(lat), 32'd3);
    for (int i = 0; i < DEPTH; i++) check("mem_fill1", 32'(mem[i]), 32'(8'h61 + i));

    // overrun while waiting for TxDone
    tick(2);
    send_byte(8'h7A);
    check("overrun_pulse", 32'(Overrun), 32'd1);
    check("overrun_no_write", 32'(BramWe), 32'd0);
    check("overrun_count", 32'(ByteCount), 32'(DEPTH));
    tick(1);
    check("overrun_one_clk", 32'(Overrun), 32'd0);

    // drop En during byte 2: it completes, then the FSM parks in RD_REQ
    k = 0;
    while (tx_cnt < 2 && k < 100) begin
      tick(1);
      k++;
    end
    check("second_start_seen", 32'(tx_cnt), 32'd2);
    En = 1'b0;
    tick(75);
    check("hold_no_start", 32'(tx_cnt), 32'd2);
    check("hold_draining", 32'(Draining), 32'd1);
    check("hold_rd_ptr", 32'(BramAddr), 32'd2);
    check("hold_count", 32'(ByteCount), 32'(DEPTH - 2));
    En = 1'b1;
    wait_idle(2000);
    check("drain1_tx_total", 32'(tx_cnt), 32'(DEPTH));
    check("drain1_overruns", 32'(ovr_cnt), 32'd1);
    check("drain1_queue_empty", 32'(exp_q.size()), 32'd0);
    check("no_7a_written", 32'(bad_write), 32'd0);

    // RX while disabled in FILL is silently dropped
    tick(1);
    En = 1'b0;
    send_byte(8'h55);
    check("disabled_no_write", 32'(BramWe), 32'd0);
    check("disabled_no_ovr", 32'(Overrun), 32'd0);
    check("disabled_count", 32'(ByteCount), 32'd0);
    En = 1'b1;

    // reset after the third TxDone of a drain
    tick(1);
    tx_base   = tx_cnt;
    done_base = done_cnt;
    fill(8'h21, DEPTH, 1'b1);
    k = 0;
    while (done_cnt < done_base + 3 && k < 500) begin
      tick(1);
      k++;
    end
    check("third_done_seen", 32'(done_cnt - done_base), 32'd3);
    tick(1);
    Rst = 1'b1;
    tick(1);
    check_all_zero("midreset");
    check("midreset_tx_sent", 32'(tx_cnt - tx_base), 32'd3);
    Rst = 1'b0;
    exp_q.delete();
    tick(1);
    fill(8'h11, DEPTH, 1'b1);
    tick(3);
    for (int i = 0; i < DEPTH; i++) check("mem_fill2", 32'(mem[i]), 32'(8'h11 + i));
    wait_idle(2000);
    check("drain2_tx_total", 32'(tx_cnt - tx_base), 32'(3 + DEPTH));
    check("drain2_queue_empty", 32'(exp_q.size()), 32'd0);

    // partial buffer followed by a long idle gap
    tick(1);
    tx_base = tx_cnt;
`ifdef UART_BRAM_TIMEOUT_FLUSH_EN
    fill(8'h31, 3, 1'b1);
    tick(2);
    check("flush_pending_count", 32'(ByteCount), 32'd3);
    tick(TB_TIMEOUT);
    wait_idle(TB_TIMEOUT + 400);
    check("flush_tx_total", 32'(tx_cnt - tx_base), 32'd3);
    check("flush_queue_empty", 32'(exp_q.size()), 32'd0);
`else
    fill(8'h31, 3, 1'b0);
    tick(TB_TIMEOUT + 200);
    check("no_flush_tx", 32'(tx_cnt - tx_base), 32'd0);
    check("no_flush_count", 32'(ByteCount), 32'd3);
    check("no_flush_draining", 32'(Draining), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
